// File: rtl/requant_param_sched.sv
// requant_param_sched
// Per-channel parameter scheduler for the requant stage. Three tables (bias,
// multiplier m, shift e) are indexed by output channel (column). For each
// ROWS x COLS tile they are replayed as three independent AXI-Stream beat
// sequences, one beat per accumulator element in row-major order.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/sel/addr/wdata table write port (sel 0=bias, 1=m, 2=e, 3=reserved)
//   start, num_cols,      tile launch with its geometry, taken in IDLE only
//   num_rows
//   busy                  tile in progress (includes the done cycle)
//   done                  one-cycle pulse once all three streams have drained
//   cfg_err               one-cycle pulse for a rejected write or start
//   bias_t*, m_t*, e_t*   parameter streams, each with its own tready
module requant_param_sched #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  parameter int MAX_CH  = 64,
  parameter int ROW_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [$clog2(MAX_CH)-1:0] cfg_addr,
  input  logic [D_W_ACC-1:0]        cfg_wdata,
  input  logic                      start,
  input  logic [$clog2(MAX_CH):0]   num_cols,
  input  logic [ROW_W-1:0]          num_rows,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic [D_W_ACC-1:0]        bias_tdata,
  output logic                      bias_tlast,
  output logic                      bias_tvalid,
  input  logic                      bias_tready,
  output logic [D_W_ACC-1:0]        m_tdata,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [D_W-1:0]            e_tdata,
  output logic                      e_tlast,
  output logic                      e_tvalid,
  input  logic                      e_tready
);

  localparam int AW = $clog2(MAX_CH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r, state_n;
  logic   busy_r, done_r, cfg_err_r;

  logic [CW-1:0]    ncols_r;
  logic [ROW_W-1:0] nrows_r;
  logic [CW-1:0]    ncols_m1_s;
  logic [ROW_W-1:0] nrows_m1_s;

  logic [D_W_ACC-1:0] bias_tab [MAX_CH];
  logic [D_W_ACC-1:0] m_tab    [MAX_CH];
  logic [D_W-1:0]     e_tab    [MAX_CH];

  logic [D_W_ACC-1:0] bias_data_r, m_data_r;
  logic [D_W-1:0]     e_data_r;

  logic bad_geom_s, start_ok_s, wr_ok_s, err_s, first_last_s, all_fin_s;

  // Per-stream handshake and sequencing signals, index 0=bias, 1=m, 2=e.
  logic          ready_s    [3];
  logic          tvalid_s   [3];
  logic          tlast_s    [3];
  logic          fin_s      [3];
  logic          load_s     [3];
  logic          byp_s      [3];
  logic [AW-1:0] load_col_s [3];

  assign ready_s[0] = bias_tready;
  assign ready_s[1] = m_tready;
  assign ready_s[2] = e_tready;

  // Launch qualification, write legality and error pulse source.
  always_comb begin
    bad_geom_s   = (num_cols == {CW{1'b0}}) || (num_cols > CW'(MAX_CH)) ||
                   (num_rows == {ROW_W{1'b0}});
    start_ok_s   = (state_r == ST_IDLE) && start && !bad_geom_s;
    wr_ok_s      = cfg_we && (state_r == ST_IDLE) && (cfg_sel != 2'd3) &&
                   ({1'b0, cfg_addr} < CW'(MAX_CH));
    err_s        = (cfg_we && !wr_ok_s) ||
                   ((state_r == ST_IDLE) && start && bad_geom_s);
    first_last_s = (num_cols == CW'(1)) && (num_rows == ROW_W'(1));
    ncols_m1_s   = ncols_r - CW'(1);
    nrows_m1_s   = nrows_r - ROW_W'(1);
    all_fin_s    = fin_s[0] && fin_s[1] && fin_s[2];
  end

  // Tile sequencing: RUN until every stream has sent its last beat, then one DONE cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_n = ST_RUN;
        else            state_n = ST_IDLE;
      end
      ST_RUN: begin
        if (all_fin_s) state_n = ST_DONE;
        else           state_n = ST_RUN;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, status outputs and latched tile geometry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      ncols_r   <= {CW{1'b0}};
      nrows_r   <= {ROW_W{1'b0}};
    end else begin
      state_r   <= state_n;
      busy_r    <= (state_n != ST_IDLE);
      done_r    <= (state_n == ST_DONE);
      cfg_err_r <= err_s;
      if (start_ok_s) begin
        ncols_r <= num_cols;
        nrows_r <= num_rows;
      end
    end
  end

  // Parameter tables: no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      case (cfg_sel)
        2'd0:    bias_tab[cfg_addr] <= cfg_wdata;
        2'd1:    m_tab[cfg_addr]    <= cfg_wdata;
        2'd2:    e_tab[cfg_addr]    <= cfg_wdata[D_W-1:0];
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_str
    logic [AW-1:0]    col_r, col_nx_s;
    logic [ROW_W-1:0] row_r, row_nx_s;
    logic             valid_r, last_r, xfer_s, last_nx_s;

    // Next (col,row) position and whether that position is the tile's final beat.
    always_comb begin
      xfer_s = valid_r && ready_s[k];
      if ({1'b0, col_r} == ncols_m1_s) begin
        col_nx_s = {AW{1'b0}};
        row_nx_s = row_r + ROW_W'(1);
      end else begin
        col_nx_s = col_r + AW'(1);
        row_nx_s = row_r;
      end
      last_nx_s = ({1'b0, col_nx_s} == ncols_m1_s) && (row_nx_s == nrows_m1_s);
    end

    assign tvalid_s[k]   = valid_r;
    assign tlast_s[k]    = last_r;
    assign fin_s[k]      = !valid_r || (xfer_s && last_r);
    assign load_s[k]     = start_ok_s || (xfer_s && !last_r);
    assign load_col_s[k] = start_ok_s ? {AW{1'b0}} : col_nx_s;
    // A write to column 0 in the launch cycle must reach the first beat directly.
    assign byp_s[k]      = start_ok_s && wr_ok_s && (cfg_sel == 2'(k)) &&
                           (cfg_addr == {AW{1'b0}});

    // Stream position/valid/last; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        col_r   <= {AW{1'b0}};
        row_r   <= {ROW_W{1'b0}};
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else if (start_ok_s) begin
        col_r   <= {AW{1'b0}};
        row_r   <= {ROW_W{1'b0}};
        valid_r <= 1'b1;
        last_r  <= first_last_s;
      end else if (xfer_s) begin
        if (last_r) begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end else begin
          col_r  <= col_nx_s;
          row_r  <= row_nx_s;
          last_r <= last_nx_s;
        end
      end
    end
  end

  // Registered stream payloads, reloaded at launch and after each non-final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_data_r <= {D_W_ACC{1'b0}};
      m_data_r    <= {D_W_ACC{1'b0}};
      e_data_r    <= {D_W{1'b0}};
    end else begin
      if (load_s[0]) bias_data_r <= byp_s[0] ? cfg_wdata : bias_tab[load_col_s[0]];
      if (load_s[1]) m_data_r    <= byp_s[1] ? cfg_wdata : m_tab[load_col_s[1]];
      if (load_s[2]) e_data_r    <= byp_s[2] ? cfg_wdata[D_W-1:0] : e_tab[load_col_s[2]];
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;
  assign bias_tdata  = bias_data_r;
  assign bias_tlast  = tlast_s[0];
  assign bias_tvalid = tvalid_s[0];
  assign m_tdata     = m_data_r;
  assign m_tlast     = tlast_s[1];
  assign m_tvalid    = tvalid_s[1];
  assign e_tdata     = e_data_r;
  assign e_tlast     = tlast_s[2];
  assign e_tvalid    = tvalid_s[2];

endmodule
